ram_sized_access: RTL and testbench
===================================

RAM_SIZED_ACCESS -- requirements
Module: ram_sized_access

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to MOC; legal range 1..15.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MOV  input  1  memory operation valid (request), four-phase handshake.
REQ-006 SHALL have port ReadWrite  input  1  1 = read, 0 = write.
REQ-007 SHALL have port Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port SignExt  input  1  reads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port Address  input  ADDR_W  byte address.
REQ-010 SHALL have port DataIn  input  32  write data, right-justified for byte/halfword.
REQ-011 SHALL have port DataOut  output  32  read data, right-justified and extended.
REQ-012 SHALL have port MOC  output  1  memory operation complete.
REQ-013 SHALL have port AlignErr  output  1  completed operation was misaligned or illegal.
REQ-014 SHALL have port Busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 IDLE -> WAIT on rising edge with MOV=1; ReadWrite, Size, SignExt, Address, DataIn captured at that edge; later input changes ignored.
REQ-017 WAIT SHALL count LATENCY-1 cycles, then enter DONE; MOC high exactly LATENCY cycles after acceptance edge (LATENCY=1: DONE directly from IDLE).
REQ-018 DONE SHALL hold MOC=1 while MOV=1; on edge with MOV=0, MOC->0 and state->IDLE.
REQ-019 A new request SHALL require MOV low for at least one edge after DONE; MOV held high never re-triggers.
REQ-020 Memory SHALL be big-endian: byte at Address is most significant byte of halfword/word.
REQ-021 Word access SHALL need Address[1:0]=00, halfword Address[0]=0; otherwise, or Size=11, the operation is misaligned.
REQ-022 Misaligned operation SHALL not modify memory, SHALL complete with normal latency, AlignErr=1 and DataOut=0 while MOC=1.
REQ-023 Aligned write SHALL update only addressed bytes, on the edge entering DONE; byte from DataIn[7:0], halfword from DataIn[15:0].
REQ-024 Aligned read SHALL present data on DataOut on the edge entering DONE, stable while MOC=1; byte/halfword extended per captured SignExt.
REQ-025 DataOut SHALL hold its last value outside DONE; write completion SHALL not change DataOut.
REQ-026 AlignErr SHALL be valid only while MOC=1 and cleared on return to IDLE.
REQ-027 Address arithmetic SHALL be modulo 2**ADDR_W; no out-of-range condition exists.

Reset
REQ-028 Reset SHALL immediately force state IDLE, MOC=0, AlignErr=0, Busy=0, DataOut=0, counter=0.
REQ-029 Reset during WAIT SHALL discard the pending operation; memory contents SHALL be unaffected by reset.
REQ-030 Memory array SHALL be accessible hierarchically as Mem[0 .. 2**ADDR_W-1], 8 bits per entry, for bench preload.

Verification
REQ-031 Preload Mem[0..3]=12,34,56,78 hex; word read addr 0, LATENCY=2 -> MOC high 2 cycles after accept, DataOut=32'h12345678.
REQ-032 Byte read addr 4 holding 8'hF0, SignExt=1 -> DataOut=32'hFFFFFFF0; SignExt=0 -> 32'h000000F0.
REQ-033 Halfword write 16'hBEEF to addr 6, then word read addr 4 -> bytes 6,7 = BE,EF; bytes 4,5 unchanged.
REQ-034 Word write addr 2 -> AlignErr=1 with MOC, DataOut=0, Mem[0..7] unchanged; Size=11 read -> AlignErr=1.
REQ-035 MOV held high 5 cycles past MOC -> MOC stays high, no second access; MOV low one edge -> IDLE, Busy=0.
REQ-036 Reset asserted mid-WAIT on a write -> MOC never rises, target bytes unchanged, all outputs zero.

Source files
------------

// File: rtl/ram_sized_access.sv
// Byte-addressed big-endian RAM with byte/halfword/word access, a fixed-latency
// four-phase MOV/MOC handshake and alignment checking.
module ram_sized_access #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MOV,
    input  logic              ReadWrite,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              AlignErr,
    output logic              Busy
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       dout_q, dout_d;
    logic              aerr_q, aerr_d;

    logic [7:0] Mem [0:DEPTH-1];

    logic              in_idle;
    logic              op_rw;
    logic [1:0]        op_size;
    logic              op_sext;
    logic [ADDR_W-1:0] op_addr, a1, a2, a3;
    logic [31:0]       op_din;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       rdata;
    logic              misaligned;
    logic              complete;

    // With LATENCY=1 the access completes on the acceptance edge itself, so the
    // operation is taken from the live inputs in IDLE and from the capture otherwise.
    always_comb begin
        in_idle = (state_q == IDLE);
        op_rw   = in_idle ? ReadWrite : rw_q;
        op_size = in_idle ? Size      : size_q;
        op_sext = in_idle ? SignExt   : sext_q;
        op_addr = in_idle ? Address   : addr_q;
        op_din  = in_idle ? DataIn    : din_q;
        a1 = op_addr + ADDR_W'(1);
        a2 = op_addr + ADDR_W'(2);
        a3 = op_addr + ADDR_W'(3);
        b0 = Mem[op_addr];
        b1 = Mem[a1];
        b2 = Mem[a2];
        b3 = Mem[a3];
        case (op_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = op_addr[0];
            2'b10:   misaligned = |op_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        case (op_size)
            2'b00:   rdata = {{24{op_sext & b0[7]}}, b0};
            2'b01:   rdata = {{16{op_sext & b0[7]}}, b0, b1};
            default: rdata = {b0, b1, b2, b3};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        size_d   = size_q;
        sext_d   = sext_q;
        addr_d   = addr_q;
        din_d    = din_q;
        dout_d   = dout_q;
        aerr_d   = aerr_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    rw_d   = ReadWrite;
                    size_d = Size;
                    sext_d = SignExt;
                    addr_d = Address;
                    din_d  = DataIn;
                    if (LAT_M1 == 4'd0) begin
                        state_d  = DONE;
                        complete = 1'b1;
                        cnt_d    = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_M1) begin
                    state_d  = DONE;
                    complete = 1'b1;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (!MOV) begin
                    state_d = IDLE;
                    aerr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            aerr_d = misaligned;
            if (misaligned)
                dout_d = 32'd0;
            else if (op_rw)
                dout_d = rdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= 32'd0;
            dout_q  <= 32'd0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            aerr_q  <= aerr_d;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive Reset.
    always_ff @(posedge Clk) begin
        if (complete && !op_rw && !misaligned && !Reset) begin
            case (op_size)
                2'b00: Mem[op_addr] <= op_din[7:0];
                2'b01: begin
                    Mem[op_addr] <= op_din[15:8];
                    Mem[a1]      <= op_din[7:0];
                end
                default: begin
                    Mem[op_addr] <= op_din[31:24];
                    Mem[a1]      <= op_din[23:16];
                    Mem[a2]      <= op_din[15:8];
                    Mem[a3]      <= op_din[7:0];
                end
            endcase
        end
    end

    assign DataOut  = dout_q;
    assign AlignErr = aerr_q;
    assign MOC      = (state_q == DONE);
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_sized_access.sv
// Directed bench for ram_sized_access (ADDR_W=9, LATENCY=2): sized reads/writes,
// alignment errors, MOV hold behaviour and reset during a pending write.
module tb_ram_sized_access;

    logic        Clk;
    logic        Reset;
    logic        MOV;
    logic        ReadWrite;
    logic [1:0]  Size;
    logic        SignExt;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        AlignErr;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    ram_sized_access #(.ADDR_W(9), .LATENCY(2)) dut (
        .Clk(Clk), .Reset(Reset), .MOV(MOV), .ReadWrite(ReadWrite), .Size(Size),
        .SignExt(SignExt), .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
        .MOC(MOC), .AlignErr(AlignErr), .Busy(Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drives one complete handshake; inputs are scrambled after acceptance so a
    // design that fails to capture them returns wrong results. lat counts edges
    // from acceptance (acceptance edge = 1) until MOC is seen.
    task automatic do_op(input logic rw, input logic [1:0] sz, input logic se,
                         input logic [8:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] dout, output logic aerr);
        @(negedge Clk);
        MOV = 1'b1; ReadWrite = rw; Size = sz; SignExt = se; Address = a; DataIn = d;
        @(posedge Clk); #1;
        lat = 1;
        ReadWrite = ~rw; Size = ~sz; SignExt = ~se; Address = a ^ 9'h1FF; DataIn = ~d;
        while (MOC !== 1'b1 && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        dout = DataOut;
        aerr = AlignErr;
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (Busy !== 1'b0 || MOC !== 1'b0 || AlignErr !== 1'b0 || DataOut !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: Busy=%b MOC=%b AlignErr=%b DataOut=%h, required all zero",
                     Busy, MOC, AlignErr, DataOut);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_word_read();
        int lat; logic [31:0] dout; logic aerr;
        do_op(1'b1, 2'b10, 1'b0, 9'd0, 32'd0, lat, dout, aerr);
        $display("word read addr 0: lat=%0d DataOut=%h AlignErr=%b", lat, dout, aerr);
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL word_read_latency: got %0d, required 2", lat);
        end
        checks++;
        if (dout !== 32'h12345678 || aerr !== 1'b0) begin
            failures++; $display("FAIL word_read_data: got %h/%b, required 12345678/0", dout, aerr);
        end
        checks++;
        if (Busy !== 1'b0 || MOC !== 1'b0) begin
            failures++; $display("FAIL word_read_idle: Busy=%b MOC=%b, required 0/0", Busy, MOC);
        end
        do_op(1'b1, 2'b10, 1'b0, 9'h1FC, 32'd0, lat, dout, aerr);
        $display("word read addr 1FC: DataOut=%h", dout);
        checks++;
        if (dout !== 32'h01020304) begin
            failures++; $display("FAIL word_read_top: got %h, required 01020304", dout);
        end
    endtask

    task automatic test_byte_read_ext();
        int lat; logic [31:0] dout; logic aerr;
        do_op(1'b1, 2'b00, 1'b1, 9'd4, 32'd0, lat, dout, aerr);
        $display("byte read addr 4 sext=1: DataOut=%h", dout);
        checks++;
        if (dout !== 32'hFFFFFFF0) begin
            failures++; $display("FAIL byte_sext: got %h, required FFFFFFF0", dout);
        end
        do_op(1'b1, 2'b00, 1'b0, 9'd4, 32'd0, lat, dout, aerr);
        $display("byte read addr 4 sext=0: DataOut=%h", dout);
        checks++;
        if (dout !== 32'h000000F0) begin
            failures++; $display("FAIL byte_zext: got %h, required 000000F0", dout);
        end
        do_op(1'b1, 2'b01, 1'b1, 9'd4, 32'd0, lat, dout, aerr);
        $display("half read addr 4 sext=1: DataOut=%h", dout);
        checks++;
        if (dout !== 32'hFFFFF0A5) begin
            failures++; $display("FAIL half_sext: got %h, required FFFFF0A5", dout);
        end
    endtask

    task automatic test_half_write();
        int lat; logic [31:0] dout; logic aerr;
        do_op(1'b0, 2'b01, 1'b0, 9'd6, 32'h1234BEEF, lat, dout, aerr);
        $display("half write BEEF addr 6: DataOut=%h AlignErr=%b lat=%0d", dout, aerr, lat);
        checks++;
        if (dout !== 32'hFFFFF0A5 || aerr !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL half_write_outputs: got %h/%b/%0d, required FFFFF0A5/0/2", dout, aerr, lat);
        end
        do_op(1'b1, 2'b10, 1'b0, 9'd4, 32'd0, lat, dout, aerr);
        $display("word read addr 4: DataOut=%h", dout);
        checks++;
        if (dout !== 32'hF0A5BEEF) begin
            failures++; $display("FAIL half_write_readback: got %h, required F0A5BEEF", dout);
        end
        do_op(1'b0, 2'b00, 1'b0, 9'd5, 32'hDEADBE5A, lat, dout, aerr);
        do_op(1'b1, 2'b10, 1'b0, 9'd4, 32'd0, lat, dout, aerr);
        $display("byte write 5A addr 5, word read addr 4: DataOut=%h", dout);
        checks++;
        if (dout !== 32'hF05ABEEF) begin
            failures++; $display("FAIL byte_write_readback: got %h, required F05ABEEF", dout);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] dout; logic aerr;
        logic [7:0] exp_mem [0:7];
        int bad;
        exp_mem = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hF0, 8'h5A, 8'hBE, 8'hEF};
        do_op(1'b0, 2'b10, 1'b0, 9'd2, 32'hCAFEBABE, lat, dout, aerr);
        $display("word write addr 2: DataOut=%h AlignErr=%b lat=%0d", dout, aerr, lat);
        checks++;
        if (aerr !== 1'b1 || dout !== 32'd0 || lat != 2) begin
            failures++;
            $display("FAIL misaligned_write: got %h/%b/%0d, required 00000000/1/2", dout, aerr, lat);
        end
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (dut.Mem[i] !== exp_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL misaligned_mem: %0d bytes of Mem[0..7] changed, required 0", bad);
        end
        checks++;
        if (AlignErr !== 1'b0) begin
            failures++; $display("FAIL aerr_cleared: got %b, required 0", AlignErr);
        end
        do_op(1'b1, 2'b11, 1'b0, 9'd0, 32'd0, lat, dout, aerr);
        $display("size=11 read addr 0: DataOut=%h AlignErr=%b", dout, aerr);
        checks++;
        if (aerr !== 1'b1 || dout !== 32'd0) begin
            failures++; $display("FAIL illegal_size: got %h/%b, required 00000000/1", dout, aerr);
        end
        do_op(1'b1, 2'b01, 1'b0, 9'd1, 32'd0, lat, dout, aerr);
        $display("half read addr 1: DataOut=%h AlignErr=%b", dout, aerr);
        checks++;
        if (aerr !== 1'b1 || dout !== 32'd0) begin
            failures++; $display("FAIL misaligned_half: got %h/%b, required 00000000/1", dout, aerr);
        end
        do_op(1'b1, 2'b00, 1'b0, 9'd3, 32'd0, lat, dout, aerr);
        $display("byte read addr 3: DataOut=%h AlignErr=%b", dout, aerr);
        checks++;
        if (aerr !== 1'b0 || dout !== 32'h00000078) begin
            failures++; $display("FAIL odd_byte_read: got %h/%b, required 00000078/0", dout, aerr);
        end
    endtask

    task automatic test_hold_mov();
        int lat;
        int bad;
        @(negedge Clk);
        MOV = 1'b1; ReadWrite = 1'b1; Size = 2'b00; SignExt = 1'b0; Address = 9'd0;
        @(posedge Clk); #1;
        Address = 9'd1;
        lat = 1;
        while (MOC !== 1'b1 && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL hold_latency: got %0d, required 2", lat);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            if (MOC !== 1'b1 || Busy !== 1'b1 || DataOut !== 32'h00000012) bad++;
        end
        $display("MOV held 5 cycles past MOC: MOC=%b DataOut=%h", MOC, DataOut);
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL hold_mov: %0d bad cycles, required 0 (MOC=1, DataOut=00000012)", bad);
        end
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b0 || MOC !== 1'b0 || DataOut !== 32'h00000012) begin
            failures++;
            $display("FAIL hold_release: Busy=%b MOC=%b DataOut=%h, required 0/0/00000012", Busy, MOC, DataOut);
        end
    endtask

    task automatic test_reset_mid_wait();
        int moc_seen;
        @(negedge Clk);
        MOV = 1'b1; ReadWrite = 1'b0; Size = 2'b10; SignExt = 1'b0; Address = 9'd8;
        DataIn = 32'hAABBCCDD;
        @(posedge Clk); #1;
        checks++;
        if (Busy !== 1'b1 || MOC !== 1'b0) begin
            failures++; $display("FAIL rst_wait_entry: Busy=%b MOC=%b, required 1/0", Busy, MOC);
        end
        #2 Reset = 1'b1;
        #1;
        $display("reset mid-WAIT: Busy=%b MOC=%b AlignErr=%b DataOut=%h", Busy, MOC, AlignErr, DataOut);
        checks++;
        if (Busy !== 1'b0 || MOC !== 1'b0 || AlignErr !== 1'b0 || DataOut !== 32'd0) begin
            failures++;
            $display("FAIL rst_async: Busy=%b MOC=%b AlignErr=%b DataOut=%h, required all zero",
                     Busy, MOC, AlignErr, DataOut);
        end
        moc_seen = 0;
        @(posedge Clk); #1;
        if (MOC !== 1'b0) moc_seen++;
        @(negedge Clk);
        Reset = 1'b0; MOV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            if (MOC !== 1'b0 || Busy !== 1'b0) moc_seen++;
        end
        checks++;
        if (moc_seen != 0) begin
            failures++; $display("FAIL rst_no_moc: MOC/Busy high in %0d cycles, required 0", moc_seen);
        end
        checks++;
        if (dut.Mem[8] !== 8'h00 || dut.Mem[9] !== 8'h00 || dut.Mem[10] !== 8'h00 || dut.Mem[11] !== 8'h00) begin
            failures++;
            $display("FAIL rst_mem: Mem[8..11]=%h %h %h %h, required 00 00 00 00",
                     dut.Mem[8], dut.Mem[9], dut.Mem[10], dut.Mem[11]);
        end
    endtask

    initial begin
        Reset = 1'b1; MOV = 1'b0; ReadWrite = 1'b0; Size = 2'b00; SignExt = 1'b0;
        Address = 9'd0; DataIn = 32'd0;
        for (int i = 0; i < 512; i++) dut.Mem[i] = 8'h00;
        dut.Mem[0] = 8'h12; dut.Mem[1] = 8'h34; dut.Mem[2] = 8'h56; dut.Mem[3] = 8'h78;
        dut.Mem[4] = 8'hF0; dut.Mem[5] = 8'hA5; dut.Mem[6] = 8'h11; dut.Mem[7] = 8'h22;
        dut.Mem[508] = 8'h01; dut.Mem[509] = 8'h02; dut.Mem[510] = 8'h03; dut.Mem[511] = 8'h04;

        test_reset();
        test_word_read();
        test_byte_read_ext();
        test_half_write();
        test_misaligned();
        test_hold_mov();
        test_reset_mid_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
